sequential_multiplier: RTL and testbench

//   Bit-serial shift-add unsigned multiplier for the bit-serial MAC datapath.
//   - Multiplicand: loaded in parallel.
//   - Multiplier: arrives one bit per clock, LSB first, on a serial input.
//   - Output: full-width product, flagged by a one-cycle done pulse.

---
 rtl/sequential_multiplier_pkg.sv | 30 +++
 rtl/sequential_multiplier_shift_add_step.sv | 32 +++
 rtl/sequential_multiplier.sv | 148 ++++++++++++++
 tb/tb_sequential_multiplier.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sequential_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// sequential_multiplier_pkg
//   Shared definitions for the bit-serial shift-add multiplier:
//     - state_t : controller state encoding (IDLE, RUN)
//     - clog2   : bit-counter width helper
// -----------------------------------------------------------------------------
package sequential_multiplier_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width needed to hold values 0..value-1. Never returns less than 1, so a
    // counter declared with this width is always legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sequential_multiplier_shift_add_step.sv
// -----------------------------------------------------------------------------
// shift_add_step
//   One combinational shift-add step: acc_out = acc_in + (bit_in ? a_in << k_in : 0).
//   The multiplicand is zero-extended to the accumulator width before the
//   shift, so no partial-product bits are lost.
// Ports
//   acc_in   in   ACC_WIDTH  running partial sum
//   a_in     in   A_WIDTH    multiplicand
//   bit_in   in   1          current multiplier bit
//   k_in     in   K_WIDTH    weight (bit position) of the current multiplier bit
//   acc_out  out  ACC_WIDTH  updated partial sum
// -----------------------------------------------------------------------------
module shift_add_step #(
    parameter int ACC_WIDTH = 32,
    parameter int A_WIDTH   = 16,
    parameter int K_WIDTH   = 4
) (
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic [A_WIDTH-1:0]   a_in,
    input  logic                 bit_in,
    input  logic [K_WIDTH-1:0]   k_in,
    output logic [ACC_WIDTH-1:0] acc_out
);

    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] partial;

    assign a_ext   = ACC_WIDTH'(a_in);
    assign partial = bit_in ? (a_ext << k_in) : '0;
    assign acc_out = acc_in + partial;

endmodule

// File: rtl/sequential_multiplier.sv
// -----------------------------------------------------------------------------
// sequential_multiplier
//   Bit-serial shift-add unsigned multiplier. The multiplicand is loaded in
//   parallel on the start edge; the multiplier arrives LSB first, one bit per
//   clock, with bit 0 valid on the start edge. The full-width product is
//   registered and flagged by a one-cycle done pulse N-1 cycles after start.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; start edge consumes bit 0 and loads operand A
//   RUN   | consuming bits 1..N-1; last bit publishes product and pulses done
//
// Ports
//   clk                       in   1      clock, rising edge
//   rst                       in   1      asynchronous reset, active low
//   start                     in   1      begin an operation (ignored in RUN)
//   multiplicand              in   M      operand A, sampled on the start edge
//   multiplier                in   N      parallel copy of B, not used
//   multiplier_serial_bit_in  in   1      operand B, LSB first
//   product                   out  M+N    A*B, held until the next completion
//   done                      out  1      one-cycle pulse on product update
// -----------------------------------------------------------------------------
module sequential_multiplier
    import sequential_multiplier_pkg::*;
#(
    parameter int MULTIPLICAND_WIDTH = 16,
    parameter int MULTIPLIER_WIDTH   = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [MULTIPLICAND_WIDTH-1:0]                multiplicand,
    input  logic [MULTIPLIER_WIDTH-1:0]                  multiplier,
    input  logic                                         multiplier_serial_bit_in,
    output logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] product,
    output logic                                         done
);

    localparam int PROD_WIDTH = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
    localparam int CNT_WIDTH  = clog2(MULTIPLIER_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(MULTIPLIER_WIDTH - 1);

    state_t                        state;
    state_t                        state_nxt;
    logic                          load;
    logic                          finish;

    logic [MULTIPLICAND_WIDTH-1:0] a_reg;
    logic [PROD_WIDTH-1:0]         acc;
    logic [CNT_WIDTH-1:0]          cnt;

    logic [PROD_WIDTH-1:0]         step_acc_in;
    logic [MULTIPLICAND_WIDTH-1:0] step_a_in;
    logic [CNT_WIDTH-1:0]          step_k_in;
    logic [PROD_WIDTH-1:0]         step_sum;

    // The parallel multiplier copy is informational only.
    logic unused_multiplier;
    assign unused_multiplier = ^multiplier;

    // -------------------------------------------------------------------------
    // Controller
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // On the start edge the step works from a zero sum, the live multiplicand
    // input and weight 0, so bit 0 is absorbed without a dedicated cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        step_acc_in = '0;
        step_a_in   = multiplicand;
        step_k_in   = '0;
        if (state == RUN) begin
            step_acc_in = acc;
            step_a_in   = a_reg;
            step_k_in   = cnt;
        end
    end

    shift_add_step #(
        .ACC_WIDTH (PROD_WIDTH),
        .A_WIDTH   (MULTIPLICAND_WIDTH),
        .K_WIDTH   (CNT_WIDTH)
    ) u_step (
        .acc_in  (step_acc_in),
        .a_in    (step_a_in),
        .bit_in  (multiplier_serial_bit_in),
        .k_in    (step_k_in),
        .acc_out (step_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                a_reg <= multiplicand;
                acc   <= step_sum;
                cnt   <= CNT_WIDTH'(1);
            end else if (state == RUN) begin
                if (finish) begin
                    // Only the completed sum is ever exposed on product.
                    product <= step_sum;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= step_sum;
                    cnt <= cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// -----------------------------------------------------------------------------
// tb_sequential_multiplier
//   Directed bench for sequential_multiplier at M=N=4. Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_sequential_multiplier;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       multiplier_serial_bit_in;
    logic [7:0] product;
    logic       done;

    int total;
    int passed;
    logic [7:0] last_prod;

    sequential_multiplier #(
        .MULTIPLICAND_WIDTH (4),
        .MULTIPLIER_WIDTH   (4)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .multiplicand             (multiplicand),
        .multiplier               (multiplier),
        .multiplier_serial_bit_in (multiplier_serial_bit_in),
        .product                  (product),
        .done                     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input logic obs, input logic exp, input string tag);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_prod(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one operation starting at the current falling edge and returns at
    // the falling edge where done must be high. zap_a clears the multiplicand
    // input after the start edge; mid_start pulses start again during RUN.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input string tag,
                          input bit zap_a, input bit mid_start);
        start                    = 1'b1;
        multiplicand             = a;
        multiplier               = ~b;
        multiplier_serial_bit_in = b[0];
        @(negedge clk);
        check_bit(done, 1'b0, {tag, " done low c1"});
        check_prod(product, last_prod, {tag, " product held c1"});
        start                    = 1'b0;
        multiplier_serial_bit_in = b[1];
        if (zap_a) multiplicand = 4'h0;
        @(negedge clk);
        check_bit(done, 1'b0, {tag, " done low c2"});
        multiplier_serial_bit_in = b[2];
        if (mid_start) begin
            start        = 1'b1;
            multiplicand = 4'hF;
        end
        @(negedge clk);
        check_bit(done, 1'b0, {tag, " done low c3"});
        check_prod(product, last_prod, {tag, " product held c3"});
        start                    = 1'b0;
        multiplier_serial_bit_in = b[3];
        @(negedge clk);
        check_bit(done, 1'b1, {tag, " done pulse"});
        check_prod(product, exp, {tag, " product"});
        last_prod                = exp;
        multiplier_serial_bit_in = 1'b0;
    endtask

    initial begin
        total                    = 0;
        passed                   = 0;
        last_prod                = 8'h00;
        rst                      = 1'b0;
        start                    = 1'b0;
        multiplicand             = 4'h0;
        multiplier               = 4'h0;
        multiplier_serial_bit_in = 1'b0;

        #100;
        check_prod(product, 8'h00, "reset product");
        check_bit(done, 1'b0, "reset done");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: 2*6
        run_op(4'h2, 4'h6, 8'h0C, "t1 2x6", 1'b0, 1'b0);
        @(negedge clk);
        check_bit(done, 1'b0, "t1 done one cycle");
        check_prod(product, 8'h0C, "t1 product held");

        // 2: F*F with multiplicand cleared after start
        run_op(4'hF, 4'hF, 8'hE1, "t2 FxF", 1'b1, 1'b0);
        @(negedge clk);
        check_bit(done, 1'b0, "t2 done one cycle");

        // 3: zero operands
        run_op(4'h5, 4'h0, 8'h00, "t3 5x0", 1'b0, 1'b0);
        @(negedge clk);
        run_op(4'h0, 4'hF, 8'h00, "t3 0xF", 1'b0, 1'b0);
        @(negedge clk);
        check_bit(done, 1'b0, "t3 done one cycle");

        // 4: start pulsed mid-RUN is ignored
        run_op(4'h3, 4'h5, 8'h0F, "t4 3x5", 1'b0, 1'b1);
        @(negedge clk);
        check_bit(done, 1'b0, "t4 no second pulse a");
        @(negedge clk);
        check_bit(done, 1'b0, "t4 no second pulse b");
        check_prod(product, 8'h0F, "t4 product held");

        // 5: back-to-back, second start on the done cycle
        run_op(4'h9, 4'h7, 8'h3F, "t5 9x7", 1'b0, 1'b0);
        run_op(4'hF, 4'hF, 8'hE1, "t5 FxF", 1'b0, 1'b0);
        @(negedge clk);
        check_bit(done, 1'b0, "t5 done one cycle");

        // 6: reset mid-RUN aborts immediately
        start                    = 1'b1;
        multiplicand             = 4'h3;
        multiplier_serial_bit_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_prod(product, 8'h00, "t6 reset product");
        check_bit(done, 1'b0, "t6 reset done");
        @(negedge clk);
        check_bit(done, 1'b0, "t6 no pulse a");
        @(negedge clk);
        check_bit(done, 1'b0, "t6 no pulse b");
        rst       = 1'b1;
        last_prod = 8'h00;
        @(negedge clk);
        check_bit(done, 1'b0, "t6 idle after release");
        run_op(4'h2, 4'h6, 8'h0C, "t6 2x6", 1'b0, 1'b0);
        @(negedge clk);
        check_bit(done, 1'b0, "t6 done one cycle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
